// File: rtl/i2s_pkg.sv
// Constants and sample-pair type shared by the I2S transmit and capture paths.
package i2s_pkg;

    localparam int I2S_SLOT_BITS    = 32;
    localparam int I2S_SLOTS        = 2;
    localparam int I2S_BCK_PER_MCLK = 4;
    localparam int I2S_FRAME_BITS   = I2S_SLOT_BITS * I2S_SLOTS;
    localparam int AUDIO_WIDTH      = 16;

    typedef struct packed {
        logic [AUDIO_WIDTH-1:0] left;
        logic [AUDIO_WIDTH-1:0] right;
    } audio_pair_t;

endpackage

// File: rtl/i2s_tx_fifo.sv
// Two-entry FIFO of sample pairs; full_next lets the owner register a ready flag
// that tracks the occupancy after the current edge.
module i2s_tx_fifo
    import i2s_pkg::*;
#(
    parameter type T = audio_pair_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     wr_data,
    output T     rd_data,
    output logic full,
    output logic empty,
    output logic full_next
);

    T           mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    always_comb begin
        do_push  = push && (count_q != 2'd2);
        do_pop   = pop && (count_q != 2'd0);
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = mem_q[rd_ptr_q];
    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign full_next = (count_d == 2'd2);

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: MCLK/BCK/LRCK generated by counters on clk,
// 16-bit stereo pairs buffered two deep and serialised MSB one BCK after LRCK.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int MCLK_HALF = 3,
    parameter int WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_l,
    input  logic [WIDTH-1:0] sample_r,
    input  logic             sample_valid,
    output logic             sample_ready,
    output logic             i2s_mclk,
    output logic             i2s_bck,
    output logic             i2s_lrck,
    output logic             i2s_dout,
    output logic             frame_start,
    output logic             underrun
);

    localparam int DIV_TOP  = 2 * MCLK_HALF * I2S_BCK_PER_MCLK - 1;
    localparam int DIV_W    = $clog2(DIV_TOP + 1);
    localparam int MCLK_TOP = 2 * MCLK_HALF - 1;
    localparam int MCLK_W   = (MCLK_TOP > 0) ? $clog2(MCLK_TOP + 1) : 1;
    localparam int BIT_W    = $clog2(I2S_FRAME_BITS);
    localparam int SLOT_W   = $clog2(I2S_SLOT_BITS);

    typedef struct packed {
        logic [WIDTH-1:0] left;
        logic [WIDTH-1:0] right;
    } pair_t;

    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [MCLK_W-1:0] mclk_cnt_q, mclk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    pair_t             frame_q, frame_d;
    logic              mclk_q, mclk_d;
    logic              bck_q, bck_d;
    logic              lrck_q, lrck_d;
    logic              dout_q, dout_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;
    logic              ready_q, ready_d;

    logic              bit_tick, frame_tick;
    logic              push;
    logic              fifo_full, fifo_empty, fifo_full_next;
    pair_t             fifo_wr, fifo_rd;
    logic [SLOT_W-1:0] slot_pos;
    logic [WIDTH-1:0]  slot_word, shifted;

    assign fifo_wr = {sample_l, sample_r};
    assign push    = sample_valid && ready_q && !fifo_full;

    i2s_tx_fifo #(
        .T(pair_t)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (frame_tick),
        .wr_data  (fifo_wr),
        .rd_data  (fifo_rd),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .full_next(fifo_full_next)
    );

    // Outputs are registered from next-state values so each pin reflects the
    // counters held in the same cycle.
    always_comb begin
        bit_tick      = (div_cnt_q == DIV_W'(DIV_TOP));
        frame_tick    = bit_tick && (bit_cnt_q == BIT_W'(I2S_FRAME_BITS - 1));
        div_cnt_d     = bit_tick ? '0 : div_cnt_q + 1'b1;
        mclk_cnt_d    = (mclk_cnt_q == MCLK_W'(MCLK_TOP)) ? '0 : mclk_cnt_q + 1'b1;
        bit_cnt_d     = bit_tick ? bit_cnt_q + 1'b1 : bit_cnt_q;

        frame_d       = frame_q;
        if (frame_tick) frame_d = fifo_empty ? '0 : fifo_rd;
        frame_start_d = frame_tick;
        underrun_d    = frame_tick && fifo_empty;
        ready_d       = !fifo_full_next;

        mclk_d        = (int'(mclk_cnt_d) >= MCLK_HALF);
        bck_d         = (int'(div_cnt_d) >= 4 * MCLK_HALF);
        lrck_d        = bit_cnt_d[BIT_W-1];
        slot_pos      = bit_cnt_d[SLOT_W-1:0];
        slot_word     = lrck_d ? frame_d.right : frame_d.left;
        shifted       = '0;
        if ((slot_pos != '0) && (int'(slot_pos) <= WIDTH))
            shifted = slot_word >> (WIDTH - int'(slot_pos));
        dout_d        = shifted[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q     <= '0;
            mclk_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            frame_q       <= '0;
            mclk_q        <= 1'b0;
            bck_q         <= 1'b0;
            lrck_q        <= 1'b0;
            dout_q        <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
            ready_q       <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            mclk_cnt_q    <= mclk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_q       <= frame_d;
            mclk_q        <= mclk_d;
            bck_q         <= bck_d;
            lrck_q        <= lrck_d;
            dout_q        <= dout_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
            ready_q       <= ready_d;
        end
    end

    assign i2s_mclk     = mclk_q;
    assign i2s_bck      = bck_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_dout     = dout_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign sample_ready = ready_q;

endmodule
